// File: rtl/apb_mux_n_if.sv
// Bus bundle for the APB decoder/mux: the CPU-side port and the flattened peripheral-side port.
// The mux uses the slave modport; the CPU/peripheral side uses the master modport.
interface apb_mux_n_if #(
   parameter int NSLV   = 9,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                     apb_psel_cpu;
   logic                     apb_rw_cpu;
   logic [ADDR_W-1:0]        apb_addr_cpu;
   logic                     apb_enab_cpu;
   logic [DATA_W-1:0]        apb_datai_cpu;
   logic [DATA_W-1:0]        apb_datao_cpu;
   logic                     apb_ack_cpu;
   logic                     apb_err_cpu;
   logic [NSLV-1:0]          apb_slv_psel;
   logic [NSLV-1:0]          apb_slv_enab;
   logic                     apb_slv_rw;
   logic [NSLV*ADDR_W-1:0]   apb_slv_addr;
   logic [DATA_W-1:0]        apb_slv_datai;
   logic [NSLV*DATA_W-1:0]   apb_slv_datao;
   logic [NSLV-1:0]          apb_slv_ack;

   modport slave (
      input  apb_psel_cpu, apb_rw_cpu, apb_addr_cpu, apb_enab_cpu, apb_datai_cpu,
      input  apb_slv_datao, apb_slv_ack,
      output apb_datao_cpu, apb_ack_cpu, apb_err_cpu,
      output apb_slv_psel, apb_slv_enab, apb_slv_rw, apb_slv_addr, apb_slv_datai
   );

   modport master (
      output apb_psel_cpu, apb_rw_cpu, apb_addr_cpu, apb_enab_cpu, apb_datai_cpu,
      output apb_slv_datao, apb_slv_ack,
      input  apb_datao_cpu, apb_ack_cpu, apb_err_cpu,
      input  apb_slv_psel, apb_slv_enab, apb_slv_rw, apb_slv_addr, apb_slv_datai
   );
endinterface

// File: rtl/apb_mux_n.sv
// Parametrised APB decoder/mux: one CPU master to NSLV windowed slaves, with
// decode-miss/timeout error responses and a saturating error counter/log.
//
// state  | meaning
// IDLE   | waiting for CPU setup phase (psel & ~enab)
// SETUP  | selected slave sees psel, enab low
// ACCESS | selected slave sees psel+enab, waiting for ack or timeout
// RESP   | one-cycle ack (and err) back to the CPU
module apb_mux_n #(
   parameter int                     NSLV     = 9,
   parameter int                     ADDR_W   = 32,
   parameter int                     DATA_W   = 32,
   parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0,
   parameter int                     TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   apb_mux_n_if.slave        bus,
   input  logic              err_clr,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W-1:0] err_addr
);
   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic [NSLV-1:0]   sel_q, sel_dec;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [DATA_W-1:0] datai_q, rdata_q, rdata_sel;
   logic              err_q;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              start, err_evt, slv_ack, tmo_hit;

   // Scan high to low so the lowest matching index is the one left standing.
   always_comb begin
      sel_dec = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((bus.apb_addr_cpu & ~SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            sel_dec    = '0;
            sel_dec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_q[i]) rdata_sel = rdata_sel | bus.apb_slv_datao[i*DATA_W +: DATA_W];
      end
   end

   assign slv_ack = |(bus.apb_slv_ack & sel_q);
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      err_evt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.apb_psel_cpu && !bus.apb_enab_cpu) begin
               start = 1'b1;
               if (|sel_dec) begin
                  state_nxt = SETUP;
               end else begin
                  state_nxt = RESP;
                  err_evt   = 1'b1;
               end
            end
         end
         SETUP:  state_nxt = bus.apb_psel_cpu ? ACCESS : IDLE;
         ACCESS: begin
            if (!bus.apb_psel_cpu) begin
               state_nxt = IDLE;
            end else if (slv_ack) begin
               state_nxt = RESP;
            end else if (tmo_hit) begin
               state_nxt = RESP;
               err_evt   = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.apb_ack_cpu   = (state == RESP);
      bus.apb_err_cpu   = (state == RESP) && err_q;
      bus.apb_datao_cpu = (state == RESP) ? rdata_q : '0;
      bus.apb_slv_psel  = (state == SETUP || state == ACCESS) ? sel_q : '0;
      bus.apb_slv_enab  = (state == ACCESS) ? sel_q : '0;
      bus.apb_slv_rw    = rw_q;
      bus.apb_slv_datai = datai_q;
      bus.apb_slv_addr  = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_q[i]) bus.apb_slv_addr[i*ADDR_W +: ADDR_W] = addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q    <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         datai_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_cnt  <= '0;
         err_cnt  <= '0;
         err_addr <= '0;
      end else begin
         err_q   <= err_evt;
         rdata_q <= (state == ACCESS && bus.apb_psel_cpu && slv_ack && !rw_q) ? rdata_sel : '0;
         if (start) begin
            sel_q   <= sel_dec;
            addr_q  <= bus.apb_addr_cpu;
            rw_q    <= bus.apb_rw_cpu;
            datai_q <= bus.apb_datai_cpu;
         end
         if (state == ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
         else                 tmo_cnt <= '0;
         // A miss is logged in the same cycle the address is latched.
         if (err_evt) err_addr <= (state == IDLE) ? bus.apb_addr_cpu : addr_q;
         if (err_clr)                        err_cnt <= err_evt ? 8'd1 : 8'd0;
         else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_apb_mux_n.sv
// Bench for apb_mux_n: directed vector table, hand-written abort/reset/saturation
// sequences, then randomized transfers predicted by a transaction-level model.
module tb_apb_mux_n;
   localparam int NSLV = 4;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TMO  = 4;
   localparam logic [NSLV*AW-1:0] BASE = {32'h4000_3000, 32'h4000_1000, 32'h4000_1000, 32'h4000_0000};
   localparam logic [NSLV*AW-1:0] MASK = {32'h0000_0FFF, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF};

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] wdata;
      int          waits;
      logic        clr;
      int          spur;
      int          exp_sel;
      int          exp_ack;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic err_clr;
   logic [7:0]  err_cnt;
   logic [AW-1:0] err_addr;
   logic [DW-1:0] sdata [NSLV];
   logic [31:0] base_m [NSLV] = '{32'h4000_0000, 32'h4000_1000, 32'h4000_1000, 32'h4000_3000};
   logic [31:0] size_m [NSLV] = '{32'h1000, 32'h1000, 32'h100, 32'h1000};
   int nchk = 0;
   int nerr = 0;
   int mcnt = 0;
   logic [31:0] maddr = '0;
   vec_t tbl [10];

   apb_mux_n_if #(.NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_mux_n #(.NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.apb_slv_datao = '0;
      for (int i = 0; i < NSLV; i++) bus.apb_slv_datao[i*DW +: DW] = sdata[i];
   end

   initial begin
      #2ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int cyc, input logic [191:0] got, input logic [191:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NSLV; i++)
         if (a >= base_m[i] && a < base_m[i] + size_m[i]) return i;
      return -1;
   endfunction

   // Transaction-level prediction: which slave, which cycle the CPU ack lands, error and data.
   function automatic vec_t predict(input vec_t v);
      vec_t r = v;
      r.exp_sel = decode(v.addr);
      if (r.exp_sel < 0) begin
         r.exp_ack = 1; r.exp_err = 1'b1; r.exp_data = '0;
      end else if (v.waits < TMO) begin
         r.exp_ack = 3 + v.waits; r.exp_err = 1'b0; r.exp_data = v.rw ? 32'h0 : sdata[r.exp_sel];
      end else begin
         r.exp_ack = 2 + TMO; r.exp_err = 1'b1; r.exp_data = '0;
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic rw, input logic [31:0] wd, input int w,
                               input logic clr, input int spur, input int sel, input int ack,
                               input logic err, input logic [31:0] d);
      vec_t v;
      v.addr = a; v.rw = rw; v.wdata = wd; v.waits = w; v.clr = clr; v.spur = spur;
      v.exp_sel = sel; v.exp_ack = ack; v.exp_err = err; v.exp_data = d;
      return v;
   endfunction

   task automatic check_reset(input string name);
      chk(name, 0, 192'({bus.apb_ack_cpu, bus.apb_err_cpu, bus.apb_datao_cpu, bus.apb_slv_psel, bus.apb_slv_enab,
                         bus.apb_slv_rw, bus.apb_slv_datai, err_cnt, err_addr}), 192'(0));
      chk({name, "_addr"}, 0, 192'(bus.apb_slv_addr), 192'(0));
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk); #1;
         bus.apb_psel_cpu = 1'b0; bus.apb_enab_cpu = 1'b0; bus.apb_slv_ack = '0; err_clr = 1'b0;
         #1;
         chk("idle_ack", 0, 192'({bus.apb_ack_cpu, bus.apb_slv_psel}), 192'(0));
      end
   endtask

   task automatic xfer(input vec_t v);
      logic [NSLV-1:0] ack_v, e_psel, e_enab;
      logic [NSLV*AW-1:0] e_addr;
      logic e_ack;
      @(posedge clk); #1;
      bus.apb_psel_cpu = 1'b1; bus.apb_enab_cpu = 1'b0; bus.apb_addr_cpu = v.addr;
      bus.apb_rw_cpu = v.rw; bus.apb_datai_cpu = v.wdata; bus.apb_slv_ack = '0; err_clr = v.clr;
      for (int n = 1; n <= v.exp_ack; n++) begin
         @(posedge clk); #1;
         bus.apb_enab_cpu = 1'b1; err_clr = 1'b0;
         ack_v = '0;
         if (v.spur >= 0) ack_v[v.spur] = 1'b1;
         if (v.exp_sel >= 0 && n == 2 + v.waits) ack_v[v.exp_sel] = 1'b1;
         bus.apb_slv_ack = ack_v;
         #1;
         e_psel = '0; e_enab = '0;
         if (v.exp_sel >= 0 && n < v.exp_ack) begin
            e_psel[v.exp_sel] = 1'b1;
            if (n >= 2) e_enab[v.exp_sel] = 1'b1;
         end
         e_ack = (n == v.exp_ack);
         chk("cpu_slv", n, 192'({bus.apb_ack_cpu, bus.apb_err_cpu, bus.apb_datao_cpu, bus.apb_slv_psel, bus.apb_slv_enab}),
             192'({e_ack, e_ack & v.exp_err, e_ack ? v.exp_data : 32'h0, e_psel, e_enab}));
         if (n < v.exp_ack) begin
            e_addr = '0;
            if (v.exp_sel >= 0) e_addr[v.exp_sel*AW +: AW] = v.addr;
            chk("slv_addr", n, 192'(bus.apb_slv_addr), 192'(e_addr));
            chk("slv_wr", n, 192'({bus.apb_slv_rw, bus.apb_slv_datai}), 192'({v.rw, v.wdata}));
         end
         if (e_ack) begin
            if (v.exp_err) begin
               mcnt  = v.clr ? 1 : (mcnt == 255 ? 255 : mcnt + 1);
               maddr = v.addr;
            end else if (v.clr) begin
               mcnt = 0;
            end
            chk("err_log", n, 192'({err_cnt, err_addr}), 192'({mcnt[7:0], maddr}));
         end
      end
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; err_clr = 1'b0;
      bus.apb_psel_cpu = 1'b0; bus.apb_enab_cpu = 1'b0; bus.apb_rw_cpu = 1'b0;
      bus.apb_addr_cpu = '0; bus.apb_datai_cpu = '0; bus.apb_slv_ack = '0;
      sdata[0] = 32'hA0A0_0000; sdata[1] = 32'h1111_1111; sdata[2] = 32'h2222_2222; sdata[3] = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset_state");
      rst = 1'b0;

      tbl[0] = mk(32'h4000_3010, 1'b0, 32'h0,         0, 1'b0, -1,  3, 3, 1'b0, 32'hDEAD_BEEF);
      tbl[1] = mk(32'h4000_0004, 1'b1, 32'h1234_5678, 2, 1'b0, -1,  0, 5, 1'b0, 32'h0);
      tbl[2] = mk(32'h9000_0000, 1'b0, 32'h0,         0, 1'b0, -1, -1, 1, 1'b1, 32'h0);
      tbl[3] = mk(32'h4000_1010, 1'b0, 32'h0,         1, 1'b0,  2,  1, 4, 1'b0, 32'h1111_1111);
      tbl[4] = mk(32'h4000_3FFC, 1'b0, 32'h0,         7, 1'b0, -1,  3, 6, 1'b1, 32'h0);
      tbl[5] = mk(32'h4000_10F0, 1'b1, 32'h0000_55AA, 3, 1'b0,  2,  1, 6, 1'b0, 32'h0);
      tbl[6] = mk(32'h4000_2000, 1'b0, 32'h0,         0, 1'b1, -1, -1, 1, 1'b1, 32'h0);
      tbl[7] = mk(32'h4000_0FFF, 1'b0, 32'h0,         0, 1'b0, -1,  0, 3, 1'b0, 32'hA0A0_0000);
      tbl[8] = mk(32'h4000_4000, 1'b0, 32'h0,         0, 1'b0, -1, -1, 1, 1'b1, 32'h0);
      tbl[9] = mk(32'h4000_1FFC, 1'b0, 32'h0,         3, 1'b0, -1,  1, 6, 1'b0, 32'h1111_1111);
      for (int i = 0; i < 10; i++) begin
         xfer(tbl[i]);
         if (i % 2 == 1) idle(1);
      end

      // Abort in ACCESS: slave drops, no ack, nothing logged.
      @(posedge clk); #1;
      bus.apb_psel_cpu = 1'b1; bus.apb_enab_cpu = 1'b0; bus.apb_addr_cpu = 32'h4000_3004;
      bus.apb_rw_cpu = 1'b0; bus.apb_slv_ack = '0;
      @(posedge clk); #1; bus.apb_enab_cpu = 1'b1; #1;
      chk("abort_setup", 1, 192'({bus.apb_slv_psel, bus.apb_slv_enab}), 192'({4'b1000, 4'b0000}));
      @(posedge clk); #1; bus.apb_psel_cpu = 1'b0; bus.apb_enab_cpu = 1'b0; #1;
      chk("abort_access", 2, 192'({bus.apb_slv_psel, bus.apb_slv_enab}), 192'({4'b1000, 4'b1000}));
      for (int n = 3; n <= 4; n++) begin
         @(posedge clk); #2;
         chk("abort_idle", n, 192'({bus.apb_ack_cpu, bus.apb_slv_psel, bus.apb_slv_enab, err_cnt}),
             192'({1'b0, 4'b0, 4'b0, mcnt[7:0]}));
      end

      // Reset asserted while ACCESS is waiting on slave 0.
      @(posedge clk); #1;
      bus.apb_psel_cpu = 1'b1; bus.apb_enab_cpu = 1'b0; bus.apb_addr_cpu = 32'h4000_0100;
      bus.apb_rw_cpu = 1'b1; bus.apb_datai_cpu = 32'hCAFE_F00D;
      @(posedge clk); #1; bus.apb_enab_cpu = 1'b1;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      check_reset("rst_mid");
      rst = 1'b0; mcnt = 0; maddr = '0;
      idle(1);

      // Saturation: 256 misses back to back, then clear coincident with an error.
      v = predict(mk(32'h8000_0000, 1'b0, 32'h0, 0, 1'b0, -1, 0, 0, 1'b0, 32'h0));
      for (int i = 0; i < 256; i++) begin
         v.addr = 32'h8000_0000 + 32'(i);
         xfer(v);
      end
      chk("sat_255", 0, 192'(err_cnt), 192'(8'd255));
      v.clr = 1'b1;
      xfer(v);
      idle(1);
      @(posedge clk); #1; err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0; mcnt = 0;
      chk("clr_alone", 0, 192'(err_cnt), 192'(8'd0));

      for (int k = 0; k < 150; k++) begin
         int r;
         for (int i = 0; i < NSLV; i++) sdata[i] = $urandom;
         r = $urandom_range(0, 4);
         v.addr  = (r < NSLV) ? base_m[r] + ($urandom % size_m[r]) : $urandom;
         v.rw    = 1'($urandom_range(0, 1));
         v.wdata = $urandom;
         v.waits = $urandom_range(0, 5);
         v.clr   = ($urandom_range(0, 9) == 0);
         v.spur  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NSLV - 1) : -1;
         if (v.spur == decode(v.addr)) v.spur = -1;
         v = predict(v);
         xfer(v);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
